dcache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache. It sits between the pipelined core's data-memory port (dmem_* signals) and the 256-bit line-wide physical memory. It is the responder to the core's load/store initiator. It holds each request until complete and signals completion with a single-cycle mem_resp pulse, which the core uses to release its pipeline stall.

---
 rtl/dcache_if.sv | 38 +++
 rtl/dcache.sv | 133 +++++++++++++
 tb/tb_dcache.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_if.sv
// dcache_if: bundles the core-side load/store port and the line-wide
// physical memory port of the data cache.
//   master : environment view (core drives requests, memory drives fills)
//   slave  : cache view (responds to the core, initiates pmem transfers)
// Signals:
//   mem_address/mem_read/mem_write/mem_byte_enable/mem_wdata  core request
//   mem_rdata/mem_resp                                         core response
//   pmem_address/pmem_read/pmem_write/pmem_wdata               line request
//   pmem_rdata/pmem_resp                                       line response
interface dcache_if;
   logic [31:0]  mem_address;
   logic         mem_read;
   logic         mem_write;
   logic [3:0]   mem_byte_enable;
   logic [31:0]  mem_wdata;
   logic [31:0]  mem_rdata;
   logic         mem_resp;
   logic [31:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [255:0] pmem_rdata;
   logic [255:0] pmem_wdata;
   logic         pmem_resp;

   modport master (
      output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
      input  mem_rdata, mem_resp,
      input  pmem_address, pmem_read, pmem_write, pmem_wdata,
      output pmem_rdata, pmem_resp
   );

   modport slave (
      input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
      output mem_rdata, mem_resp,
      output pmem_address, pmem_read, pmem_write, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache with
// 256-bit lines. Hits respond in the request cycle; misses write back a
// dirty victim (if any), fill the line, then service the request as a hit.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-high reset (clears valid/dirty, FSM to IDLE)
//   bus  - dcache_if.slave: core request/response and pmem line port
module dcache #(
   parameter int unsigned S_INDEX  = 3,
   parameter int unsigned S_OFFSET = 5
) (
   input logic     clk,
   input logic     rst,
   dcache_if.slave bus
);
   localparam int unsigned SETS  = 1 << S_INDEX;
   localparam int unsigned TAG_W = 32 - S_INDEX - S_OFFSET;

   typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

   state_t state, next_state;

   logic [SETS-1:0]  valid;
   logic [SETS-1:0]  dirty;
   logic [TAG_W-1:0] tag_arr  [SETS];
   logic [255:0]     data_arr [SETS];

   logic [TAG_W-1:0]   addr_tag;
   logic [S_INDEX-1:0] addr_idx;
   logic [2:0]         word_sel;
   logic [7:0]         word_base;
   logic               req;
   logic               hit;
   logic [31:0]        rd_word;
   logic [31:0]        merged_word;

   // Miss address is captured when the miss starts so the transfer in
   // flight stays consistent even if the core request changes.
   logic [TAG_W-1:0]   miss_tag;
   logic [S_INDEX-1:0] miss_idx;

   logic hit_write;
   logic miss_start;
   logic install;
   logic unused_addr;

   assign addr_tag    = bus.mem_address[31 -: TAG_W];
   assign addr_idx    = bus.mem_address[S_OFFSET +: S_INDEX];
   assign word_sel    = bus.mem_address[4:2];
   assign word_base   = {word_sel, 5'b00000};
   assign unused_addr = ^bus.mem_address[1:0];

   assign req = bus.mem_read | bus.mem_write;
   assign hit = valid[addr_idx] && (tag_arr[addr_idx] == addr_tag);

   assign rd_word        = data_arr[addr_idx][word_base +: 32];
   assign bus.mem_rdata  = rd_word;
   assign bus.pmem_wdata = data_arr[miss_idx];

   always_comb begin
      merged_word = rd_word;
      for (int unsigned b = 0; b < 4; b++) begin
         if (bus.mem_byte_enable[b]) begin
            merged_word[b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
         end
      end
   end

   always_comb begin
      next_state       = state;
      bus.mem_resp     = 1'b0;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = '0;
      hit_write        = 1'b0;
      miss_start       = 1'b0;
      install          = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  bus.mem_resp = 1'b1;
                  // read+write together is handled as a write
                  hit_write    = bus.mem_write;
               end else begin
                  miss_start = 1'b1;
                  next_state = (valid[addr_idx] && dirty[addr_idx]) ? WRITEBACK : FILL;
               end
            end
         end
         WRITEBACK: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_address = {tag_arr[miss_idx], miss_idx, {S_OFFSET{1'b0}}};
            if (bus.pmem_resp) begin
               next_state = FILL;
            end
         end
         FILL: begin
            bus.pmem_read    = 1'b1;
            bus.pmem_address = {miss_tag, miss_idx, {S_OFFSET{1'b0}}};
            if (bus.pmem_resp) begin
               install    = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         valid <= '0;
         dirty <= '0;
      end else begin
         state <= next_state;
         if (miss_start) begin
            miss_tag <= addr_tag;
            miss_idx <= addr_idx;
         end
         if (hit_write) begin
            data_arr[addr_idx][word_base +: 32] <= merged_word;
            dirty[addr_idx]                     <= 1'b1;
         end
         if (install) begin
            data_arr[miss_idx] <= bus.pmem_rdata;
            tag_arr[miss_idx]  <= miss_tag;
            valid[miss_idx]    <= 1'b1;
            dirty[miss_idx]    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_dcache.sv
module tb_dcache;
   logic clk;
   logic rst;

   dcache_if bus ();

   dcache #(.S_INDEX(3), .S_OFFSET(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // ---------------- physical memory model ----------------
   logic [255:0] pmem [logic [31:0]];
   int           lat;
   int           wait_cnt;
   int           rd_count;
   int           wr_count;
   logic [31:0]  last_rd_addr;
   logic [31:0]  last_wr_addr;
   int           overlap;

   function automatic logic [255:0] pattern_line(input logic [31:0] l);
      logic [255:0] v;
      for (int w = 0; w < 8; w++) begin
         v[w*32 +: 32] = {8'hA5, l[23:5], w[2:0], 2'b00};
      end
      return v;
   endfunction

   function automatic logic [255:0] get_line(input logic [31:0] l);
      if (pmem.exists(l)) return pmem[l];
      return pattern_line(l);
   endfunction

   initial begin
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      wait_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         bus.pmem_resp = 1'b0;
         if (bus.pmem_read || bus.pmem_write) begin
            wait_cnt++;
            if (wait_cnt >= lat) begin
               wait_cnt = 0;
               bus.pmem_resp = 1'b1;
               if (bus.pmem_write) begin
                  pmem[bus.pmem_address] = bus.pmem_wdata;
                  last_wr_addr = bus.pmem_address;
                  wr_count++;
               end else begin
                  bus.pmem_rdata = get_line(bus.pmem_address);
                  last_rd_addr = bus.pmem_address;
                  rd_count++;
               end
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (bus.pmem_read && bus.pmem_write) overlap++;
   end

   // ---------------- request driver ----------------
   task automatic run_req(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [3:0] be, input logic [31:0] wd,
                          output logic [31:0] rdata, output int cyc, output bit tmo);
      @(posedge clk);
      #1;
      bus.mem_address     = a;
      bus.mem_read        = rd;
      bus.mem_write       = wr;
      bus.mem_byte_enable = be;
      bus.mem_wdata       = wd;
      cyc   = 0;
      tmo   = 1'b1;
      rdata = '0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.mem_resp) begin
            rdata = bus.mem_rdata;
            tmo   = 1'b0;
            break;
         end
         cyc++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic go_idle();
      @(posedge clk);
      #1;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        rd;
      logic        wr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        chk_rdata;
      logic [31:0] exp_rdata;
      int          exp_cyc;
      int          exp_wb;
      int          exp_fill;
      logic [31:0] exp_fill_addr;
      logic [31:0] exp_wb_addr;
   } vec_t;

   vec_t vecs[16];

   initial begin
      logic [255:0] l40;
      logic [31:0]  rdata;
      int           cyc;
      bit           tmo;
      int           rd0, wr0;
      bit           held;
      string        nm;

      rst = 1'b1;
      lat = 1;
      rd_count = 0; wr_count = 0; overlap = 0;
      last_rd_addr = '0; last_wr_addr = '0;
      bus.mem_address = '0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      bus.mem_byte_enable = '0; bus.mem_wdata = '0;

      l40 = pattern_line(32'h40);
      l40[31:0]  = 32'h1122_3344;
      l40[63:32] = 32'hDEAD_BEEF;
      pmem[32'h40] = l40;

      //            addr           rd wr be    wdata          chk rdata          cyc wb fill faddr          waddr
      vecs[0]  = '{32'h0000_0044, 1, 0, 4'h0, 32'h0,         1, 32'hDEAD_BEEF, 2, 0, 1, 32'h0000_0040, 32'h0};
      vecs[1]  = '{32'h0000_0044, 1, 0, 4'h0, 32'h0,         1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,         32'h0};
      vecs[2]  = '{32'h0000_0040, 1, 0, 4'h0, 32'h0,         1, 32'h1122_3344, 0, 0, 0, 32'h0,         32'h0};
      vecs[3]  = '{32'h0000_0040, 0, 1, 4'h9, 32'hAA00_00BB, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0};
      vecs[4]  = '{32'h0000_0040, 1, 0, 4'h0, 32'h0,         1, 32'hAA22_33BB, 0, 0, 0, 32'h0,         32'h0};
      vecs[5]  = '{32'h0000_0140, 1, 0, 4'h0, 32'h0,         1, 32'hA500_0140, 3, 1, 1, 32'h0000_0140, 32'h0000_0040};
      vecs[6]  = '{32'h0000_0040, 1, 0, 4'h0, 32'h0,         1, 32'hAA22_33BB, 2, 0, 1, 32'h0000_0040, 32'h0};
      vecs[7]  = '{32'h0000_0048, 1, 0, 4'h0, 32'h0,         1, 32'hA500_0048, 0, 0, 0, 32'h0,         32'h0};
      vecs[8]  = '{32'h0000_005C, 0, 1, 4'hF, 32'h1234_5678, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0};
      vecs[9]  = '{32'h0000_0058, 1, 1, 4'hF, 32'hCAFE_F00D, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0};
      vecs[10] = '{32'h0000_0058, 1, 0, 4'h0, 32'h0,         1, 32'hCAFE_F00D, 0, 0, 0, 32'h0,         32'h0};
      vecs[11] = '{32'h0000_005C, 1, 0, 4'h0, 32'h0,         1, 32'h1234_5678, 0, 0, 0, 32'h0,         32'h0};
      vecs[12] = '{32'h1000_0004, 1, 0, 4'h0, 32'h0,         1, 32'hA500_0004, 2, 0, 1, 32'h1000_0000, 32'h0};
      vecs[13] = '{32'h1000_0004, 1, 0, 4'h0, 32'h0,         1, 32'hA500_0004, 0, 0, 0, 32'h0,         32'h0};
      vecs[14] = '{32'h0000_0024, 0, 1, 4'h3, 32'h0BAD_F00D, 0, 32'h0,         2, 0, 1, 32'h0000_0020, 32'h0};
      vecs[15] = '{32'h0000_0024, 1, 0, 4'h0, 32'h0,         1, 32'hA500_F00D, 0, 0, 0, 32'h0,         32'h0};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_resp", {31'b0, bus.mem_resp}, 32'h0);
      chk("rst_pmem_read", {31'b0, bus.pmem_read}, 32'h0);
      chk("rst_pmem_write", {31'b0, bus.pmem_write}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // table-driven vectors, presented back to back
      for (int i = 0; i < 16; i++) begin
         rd0 = rd_count;
         wr0 = wr_count;
         run_req(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].be, vecs[i].wdata, rdata, cyc, tmo);
         $sformat(nm, "v%0d_timeout", i);
         chk(nm, {31'b0, tmo}, 32'h0);
         $sformat(nm, "v%0d_cycles", i);
         chk(nm, cyc, vecs[i].exp_cyc);
         if (vecs[i].chk_rdata) begin
            $sformat(nm, "v%0d_rdata", i);
            chk(nm, rdata, vecs[i].exp_rdata);
         end
         $sformat(nm, "v%0d_wb_count", i);
         chk(nm, wr_count - wr0, vecs[i].exp_wb);
         $sformat(nm, "v%0d_fill_count", i);
         chk(nm, rd_count - rd0, vecs[i].exp_fill);
         if (vecs[i].exp_fill > 0) begin
            $sformat(nm, "v%0d_fill_addr", i);
            chk(nm, last_rd_addr, vecs[i].exp_fill_addr);
         end
         if (vecs[i].exp_wb > 0) begin
            $sformat(nm, "v%0d_wb_addr", i);
            chk(nm, last_wr_addr, vecs[i].exp_wb_addr);
         end
      end
      go_idle();
      @(negedge clk);
      chk("idle_mem_resp", {31'b0, bus.mem_resp}, 32'h0);

      // reset in the middle of a fill
      lat = 20;
      @(posedge clk);
      #1;
      bus.mem_address = 32'h0000_0060;
      bus.mem_read    = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mid_fill_pmem_read", {31'b0, bus.pmem_read}, 32'h1);
      chk("mid_fill_addr", bus.pmem_address, 32'h0000_0060);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.mem_read = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_pmem_read", {31'b0, bus.pmem_read}, 32'h0);
      chk("post_rst_pmem_write", {31'b0, bus.pmem_write}, 32'h0);
      chk("post_rst_mem_resp", {31'b0, bus.mem_resp}, 32'h0);
      lat = 1;
      rd0 = rd_count;
      run_req(32'h0000_0060, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc, tmo);
      chk("refill_timeout", {31'b0, tmo}, 32'h0);
      chk("refill_cycles", cyc, 2);
      chk("refill_fill_count", rd_count - rd0, 1);
      chk("refill_rdata", rdata, 32'hA500_0060);
      // a line resident before the reset must miss again
      run_req(32'h0000_0044, 1'b1, 1'b0, 4'h0, 32'h0, rdata, cyc, tmo);
      chk("post_rst_44_cycles", cyc, 2);
      chk("post_rst_44_rdata", rdata, 32'hDEAD_BEEF);
      go_idle();

      // slow memory: ten-cycle fill latency
      lat = 10;
      held = 1'b1;
      @(posedge clk);
      #1;
      bus.mem_address = 32'h0000_0080;
      bus.mem_read    = 1'b1;
      cyc = 0;
      tmo = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.mem_resp) begin
            rdata = bus.mem_rdata;
            tmo   = 1'b0;
            break;
         end
         if (cyc >= 1 && !(bus.pmem_read && !bus.pmem_write && bus.pmem_address == 32'h0000_0080))
            held = 1'b0;
         cyc++;
         @(posedge clk);
         #1;
      end
      chk("slow_timeout", {31'b0, tmo}, 32'h0);
      chk("slow_cycles", cyc, 11);
      chk("slow_read_held", {31'b0, held}, 32'h1);
      chk("slow_rdata", rdata, 32'hA500_0080);
      go_idle();
      @(negedge clk);
      chk("slow_single_pulse", {31'b0, bus.mem_resp}, 32'h0);

      chk("pmem_rw_overlap", overlap, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end
endmodule
